// File: rtl/gate_eval_pkg.sv
// gate_eval_pkg: shared defaults, mode encodings and stage record for gate_eval_pipe
package gate_eval_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_LANES = 4;
  localparam int DEF_STAGES = 2;
  localparam int DEF_CNT_W = 16;
  localparam logic MODE_XOR = 1'b0;
  localparam logic MODE_XNOR = 1'b1;
  typedef struct packed {
    logic valid;
    logic [DEF_LANES-1:0] lane;
  } stage_t;
endpackage

// File: rtl/gate_eval_lane.sv
// gate_eval_lane: combinational masked parity of one lane, inverted in XNOR mode
module gate_eval_lane
  import gate_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] mask,
  input  logic             mode,
  output logic             y
);
  assign y = ^(data & mask) ^ (mode == MODE_XNOR);
endmodule

// File: rtl/gate_eval_pipe.sv
// gate_eval_pipe: pipelined masked-parity lane evaluator; hit counter enabled by GATE_EVAL_HIT_COUNT_EN
module gate_eval_pipe
  import gate_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]       in_mask,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane,
  output logic                   out_all,
  output logic                   out_any,
  output logic [CNT_W-1:0]       hit_count
);
  typedef struct packed {
    logic valid;
    logic [LANES-1:0] lane;
  } rec_t;
  rec_t st [STAGES];
  rec_t last_d;
  logic [LANES-1:0] res;
  logic adv, all_q, any_q;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gate_eval_lane #(.WIDTH(WIDTH)) u_lane (
      .data(in_data[k*WIDTH +: WIDTH]),
      .mask(in_mask),
      .mode(in_mode),
      .y   (res[k])
    );
  end
  // value about to enter the last stage; out_all/out_any are registered alongside it
  if (STAGES == 1) begin : g_d1
    assign last_d = {in_valid, res};
  end else begin : g_dn
    assign last_d = st[STAGES-2];
  end
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign out_valid = st[STAGES-1].valid;
  assign out_lane = st[STAGES-1].lane;
  assign out_all = all_q;
  assign out_any = any_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) st[i] <= '0;
      all_q <= 1'b0;
      any_q <= 1'b0;
    end else if (adv) begin
      st[0] <= {in_valid, res};
      for (int i = 1; i < STAGES; i++) st[i] <= st[i-1];
      all_q <= &last_d.lane;
      any_q <= |last_d.lane;
    end
  end
`ifdef GATE_EVAL_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (out_valid && out_ready && all_q && cnt != '1) cnt <= cnt + CNT_W'(1);
  end
  assign hit_count = cnt;
`else
  assign hit_count = '0;
`endif
endmodule

// File: tb/tb_gate_eval_pipe.sv
// tb_gate_eval_pipe: scoreboard bench for gate_eval_pipe (default config plus LANES=1/WIDTH=8/STAGES=4/CNT_W=2)
module tb_gate_eval_pipe;
  import gate_eval_pkg::*;
  logic clk = 0, rst = 1, out_ready = 1;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic iv_a, ir_a, md_a, ov_a, oa_a, oy_a;
  logic [63:0] d_a;
  logic [15:0] m_a, hc_a;
  logic [3:0] ol_a;
  logic iv_b, ir_b, md_b, ov_b, oa_b, oy_b;
  logic [7:0] d_b, m_b;
  logic [0:0] ol_b;
  logic [1:0] hc_b;
  gate_eval_pipe u_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_data(d_a), .in_mask(m_a),
    .in_mode(md_a), .out_valid(ov_a), .out_ready(out_ready), .out_lane(ol_a), .out_all(oa_a),
    .out_any(oy_a), .hit_count(hc_a)
  );
  gate_eval_pipe #(.WIDTH(8), .LANES(1), .STAGES(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_data(d_b), .in_mask(m_b),
    .in_mode(md_b), .out_valid(ov_b), .out_ready(out_ready), .out_lane(ol_b), .out_all(oa_b),
    .out_any(oy_b), .hit_count(hc_b)
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] model_a(logic [63:0] d, logic [15:0] m, logic md);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = ^(d[k*16 +: 16] & m) ^ md;
    return r;
  endfunction
  function automatic logic model_b(logic [7:0] d, logic [7:0] m, logic md);
    return ^(d & m) ^ md;
  endfunction
  // out_ready pattern generator used during the backpressure phase
  bit use_pat = 0;
  logic [5:0] pat = 6'b101001;
  int pi = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (use_pat) begin
      out_ready = pat[pi % 6];
      pi++;
    end
  end
  typedef struct { logic [3:0] lane; int cyc; } ent_a_t;
  typedef struct { logic lane; int cyc; } ent_b_t;
  ent_a_t qa[$];
  ent_b_t qb[$];
  logic [15:0] hm_a = '0;
  logic [1:0] hm_b = '0;
  bit lat_chk = 1, stall_a = 0;
  logic [5:0] prev_a;
  always @(negedge clk) begin
    ent_a_t ea;
    if (rst) begin
      qa.delete();
      hm_a = '0;
    end else begin
      chk("a_in_ready", 64'(ir_a), 64'(!(ov_a && !out_ready)));
      chk("a_hit_count", 64'(hc_a), 64'(hm_a));
      if (stall_a) chk("a_stable", 64'({ol_a, oa_a, oy_a}), 64'(prev_a));
      if (ov_a && out_ready) begin
        n_cmp++;
        assert (qa.size() > 0) else begin
          n_bad++;
          $error("FAIL a_unexpected_output: got lane %b expected no output", ol_a);
        end
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          chk("a_lane", 64'(ol_a), 64'(ea.lane));
          chk("a_all", 64'(oa_a), 64'(&ea.lane));
          chk("a_any", 64'(oy_a), 64'(|ea.lane));
          if (lat_chk) chk("a_latency", 64'(cyc - ea.cyc), 64'(2));
`ifdef GATE_EVAL_HIT_COUNT_EN
          if (&ea.lane && hm_a != '1) hm_a = hm_a + 16'd1;
`endif
        end
      end
      if (iv_a && ir_a) qa.push_back('{model_a(d_a, m_a, md_a), cyc});
    end
    stall_a = !rst && ov_a && !out_ready;
    prev_a = {ol_a, oa_a, oy_a};
  end
  always @(negedge clk) begin
    ent_b_t eb;
    if (rst) begin
      qb.delete();
      hm_b = '0;
    end else begin
      chk("b_hit_count", 64'(hc_b), 64'(hm_b));
      if (ov_b && out_ready) begin
        n_cmp++;
        assert (qb.size() > 0) else begin
          n_bad++;
          $error("FAIL b_unexpected_output: got lane %b expected no output", ol_b);
        end
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("b_lane", 64'(ol_b), 64'(eb.lane));
          chk("b_all_eq_lane", 64'(oa_b), 64'(ol_b[0]));
          chk("b_any_eq_lane", 64'(oy_b), 64'(ol_b[0]));
          chk("b_latency", 64'(cyc - eb.cyc), 64'(4));
`ifdef GATE_EVAL_HIT_COUNT_EN
          if (eb.lane && hm_b != '1) hm_b = hm_b + 2'd1;
`endif
        end
      end
      if (iv_b && ir_b) qb.push_back('{model_b(d_b, m_b, md_b), cyc});
    end
  end
  task automatic send_a(logic [63:0] d, logic [15:0] m, logic md);
    int w = 0;
    iv_a = 1; d_a = d; m_a = m; md_a = md;
    @(negedge clk);
    while (!ir_a && w < 50) begin w++; @(negedge clk); end
    if (!ir_a) chk("a_accept_timeout", 64'(ir_a), 64'(1));
    @(posedge clk);
    #1;
  endtask
  task automatic send_b(logic [7:0] d, logic [7:0] m, logic md, output int w);
    w = 0;
    iv_b = 1; d_b = d; m_b = m; md_b = md;
    @(negedge clk);
    while (!ir_b && w < 50) begin w++; @(negedge clk); end
    if (!ir_b) chk("b_accept_timeout", 64'(ir_b), 64'(1));
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(logic [3:0] lane);
    iv_a = 0;
    @(negedge clk);
    chk("a_not_early", 64'(ov_a), 64'(0));
    @(negedge clk);
    chk("a_valid_at_2", 64'(ov_a), 64'(1));
    chk("a_dir_lane", 64'(ol_a), 64'(lane));
    chk("a_dir_all", 64'(oa_a), 64'(&lane));
    chk("a_dir_any", 64'(oy_a), 64'(|lane));
    @(posedge clk);
    #1;
  endtask
  task automatic drain(string tag);
    int w = 0;
    iv_a = 0; iv_b = 0;
    while ((qa.size() != 0 || qb.size() != 0) && w < 200) begin @(posedge clk); w++; end
    chk(tag, 64'(qa.size() + qb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    logic [63:0] d;
    logic [3:0] e;
    logic [1:0] hit_exp;
    iv_a = 0; d_a = '0; m_a = '0; md_a = 0;
    iv_b = 0; d_b = '0; m_b = '0; md_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", 64'(ov_a), 64'(0));
    chk("rst_a_lane", 64'(ol_a), 64'(0));
    chk("rst_a_all", 64'(oa_a), 64'(0));
    chk("rst_a_any", 64'(oy_a), 64'(0));
    chk("rst_a_hit", 64'(hc_a), 64'(0));
    chk("rst_b_valid", 64'(ov_b), 64'(0));
    chk("rst_b_hit", 64'(hc_b), 64'(0));
    @(posedge clk);
    #1 rst = 0;
    send_a({16'h0000, 16'h0007, 16'h0003, 16'h0001}, 16'hFFFF, MODE_XOR);
    chk_a(4'b0101);
    send_a({$urandom, $urandom}, 16'h0000, MODE_XNOR);
    chk_a(4'b1111);
    send_a({$urandom, $urandom}, 16'h0000, MODE_XOR);
    chk_a(4'b0000);
    lat_chk = 0;
    use_pat = 1;
    pi = 0;
    for (int i = 0; i < 8; i++) send_a({$urandom, $urandom}, 16'($urandom), 1'($urandom));
    drain("a_backpressure_drain");
    use_pat = 0;
    out_ready = 1;
    lat_chk = 1;
    @(posedge clk);
    #1;
    send_a({$urandom, $urandom}, 16'hFFFF, MODE_XOR);
    send_a({$urandom, $urandom}, 16'hFFFF, MODE_XNOR);
    iv_a = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("a_midrst_valid", 64'(ov_a), 64'(0));
    chk("a_midrst_hit", 64'(hc_a), 64'(0));
    @(posedge clk);
    #1;
    d = {$urandom, $urandom};
    e = model_a(d, 16'h00FF, MODE_XNOR);
    send_a(d, 16'h00FF, MODE_XNOR);
    chk_a(e);
    for (int i = 0; i < 40; i++) begin
      send_b(8'($urandom), 8'($urandom), 1'($urandom), w);
      chk("b_throughput_wait", 64'(w), 64'(0));
    end
    drain("b_sweep_drain");
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 5; i++) send_b(8'($urandom), 8'h00, MODE_XNOR, w);
    send_b(8'($urandom), 8'h00, MODE_XOR, w);
    drain("b_hit_drain");
`ifdef GATE_EVAL_HIT_COUNT_EN
    hit_exp = 2'd3;
`else
    hit_exp = 2'd0;
`endif
    @(negedge clk);
    chk("b_hit_final", 64'(hc_b), 64'(hit_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gate_eval_pipe.md
Name: gate_eval_pipe

Overview:
- Parametrised, pipelined successor to the flat gate-level parity/compare benchmark netlists.
- Evaluates LANES independent WIDTH-bit vectors per transaction and produces:
  - a per-lane masked parity (XOR or XNOR reduction);
  - an all-lanes-true flag;
  - an any-lane-true flag.
- Registered over STAGES pipeline stages, with valid/ready flow control on input and output.
- Sits between the vector source and the result collector in the contest evaluation harness.

Parameters:
- WIDTH, 16, bits per lane.
- LANES, 4, number of parallel lanes (1..16).
- STAGES, 2, pipeline depth = accept-to-output latency in cycles (1..4).
- CNT_W, 16, width of the optional hit counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts in this cycle.
- in_data  in  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- in_mask  in  WIDTH  bit-select mask, shared by all lanes.
- in_mode  in  1  0 = XOR reduce (odd parity), 1 = XNOR reduce (inverted).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_lane  out  LANES  per-lane reduction result.
- out_all  out  1  AND of out_lane.
- out_any  out  1  OR of out_lane.
- hit_count  out  CNT_W  number of accepted results with out_all=1.

Behaviour:
- Reset: all stage-valid bits clear. out_valid=0, out_lane=0, out_all=0, out_any=0, hit_count=0. Reset mid-operation drops all in-flight transactions, with no partial output.
- Lane function:
  - lane_k = ^(in_data[lane k] & in_mask) XOR in_mode.
  - mask=0 gives lane_k = in_mode.
- Pipeline control:
  - Global advance: adv = !out_valid || out_ready.
  - in_ready = adv. in_ready is combinational from out_ready and out_valid only, never from in_valid.
  - When adv=1, every stage shifts one place.
  - Stage 0 loads {in_valid, computed result}.
  - When adv=0, all stages hold.
- Latency: a transaction accepted in cycle t appears at out_valid in cycle t+STAGES when there is no stall.
- Reduction placement:
  - The lane reduction is computed before stage 0.
  - out_all and out_any are computed from the stage-(STAGES-1) register, and are registered with it.
- Ordering: strictly in-order. No loss and no duplication under any out_ready pattern.
- Output stability: while out_valid=1 && out_ready=0, all out_* signals hold stable.
- Bubbles: with in_valid=0 while adv=1, a bubble enters the pipe. Bubbles are not compressed.
- Throughput: 1 transaction per cycle when out_ready is held at 1.
- Simultaneous accept and emit in one cycle is legal and required.

Optional Feature:
- Macro GATE_EVAL_HIT_COUNT_EN.
- Defined:
  - hit_count increments by 1 on each output handshake (out_valid && out_ready) with out_all=1.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It clears only on rst.
- Undefined:
  - hit_count is tied to 0.
  - No counter flops are synthesised.
  - All other behaviour is identical.

Decomposition:
- Package gate_eval_pkg:
  - default constants for WIDTH/LANES/STAGES/CNT_W;
  - mode localparams MODE_XOR=1'b0 and MODE_XNOR=1'b1;
  - a typedef for the stage record {valid, lane[LANES-1:0]}.
- One sub-module, gate_eval_lane:
  - combinational masked reduction of one WIDTH-bit lane;
  - instantiated LANES times via generate.
- The pipeline and handshake stay in the top module.

Test Plan (default parameters unless noted):
- Basic latency:
  - Stimulus: out_ready=1; apply one transaction with in_mask=16'hFFFF, mode=0, lane0=16'h0001, lane1=16'h0003, lane2=16'h0007, lane3=16'h0000.
  - Required: exactly 2 cycles later, out_valid=1, out_lane=4'b0101, out_all=0, out_any=1.
- Mask and mode:
  - Stimulus: in_mask=16'h0000, mode=1, any data.
  - Required: out_lane=4'b1111, out_all=1, out_any=1.
  - Stimulus: same with mode=0.
  - Required: out_lane=4'b0000, out_any=0.
- Backpressure:
  - Stimulus: stream 8 transactions back-to-back while out_ready toggles 1,0,0,1,0,1...
  - Required:
    - all 8 results emerge in order, none lost or duplicated;
    - out_* stable on every stalled cycle;
    - in_ready=0 exactly on cycles where out_valid=1 && out_ready=0.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 2 transactions in flight.
  - Required:
    - next cycle, out_valid=0 and hit_count=0;
    - the in-flight results never appear;
    - a new transaction afterwards appears 2 cycles after acceptance.
- Hit counter, GATE_EVAL_HIT_COUNT_EN defined, CNT_W=2:
  - Stimulus: 5 out_all=1 results, then 1 out_all=0 result.
  - Required: hit_count sequence 1,2,3,3,3, unchanged by the out_all=0 result.
  - Stimulus: same run with the macro undefined.
  - Required: hit_count=0 throughout.
- Parameter sweep:
  - Stimulus: LANES=1, WIDTH=8, STAGES=4, random traffic against a reference model.
  - Required: latency 4, throughput 1/cycle with out_ready=1, and out_all == out_any == out_lane[0].
